// File: rtl/boron_inv_sub_unit_if.sv
// ---------------------------------------------------------------------------
// boron_inv_sub_unit_if
//
// Purpose : Groups the job-input and result-output handshakes of the BORON
//           inverse-substitution unit into one bundle.
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid and ready are both high. A producer holds valid and its
// payload stable until that transfer. A producer never waits for ready
// before raising valid. Ready may be high while valid is low.
//
// Signals :
//   in_valid   master->slave  in_state/in_key carry a job
//   in_ready   slave->master  unit can accept a job
//   in_state   master->slave  64-bit ciphertext-side state, nibble k = [4k+3:4k]
//   in_key     master->slave  64-bit round key XORed after substitution
//   out_valid  slave->master  out_state carries a result
//   out_ready  master->slave  downstream accepts out_state
//   out_state  slave->master  InvS(in_state) XOR in_key
// ---------------------------------------------------------------------------
interface boron_inv_sub_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_state;
    logic [63:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_state;

    // Unit side.
    modport slave (
        input  in_valid,
        input  in_state,
        input  in_key,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state
    );

    // Job source / result sink side.
    modport master (
        output in_valid,
        output in_state,
        output in_key,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state
    );
endinterface

// File: rtl/boron_inv_sub_unit.sv
// ---------------------------------------------------------------------------
// boron_inv_sub_unit
//
// Purpose : Decryption-side substitution stage of the BORON round loop.
//           Applies the inverse 4-bit S-box to all 16 nibbles of a 64-bit
//           state, NPC nibbles per clock (nibble 0 first), then XORs in the
//           round key and presents the result.
//
// Parameters:
//   NPC        nibbles substituted per cycle; 1, 2, 4, 8 or 16
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   bus        slave modport of boron_inv_sub_unit_if (job in / result out)
//   busy       high whenever the FSM is not IDLE
//   dbg_state  current FSM state (0=IDLE, 1=SUB, 2=KEY, 3=DONE)
//
// Timing : accept edge -> out_valid after 16/NPC+1 edges. Every output is
//          decoded from registers only; no input reaches an output
//          combinationally.
// ---------------------------------------------------------------------------
module boron_inv_sub_unit #(
    parameter int NPC = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    boron_inv_sub_unit_if.slave        bus,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter check
    // -----------------------------------------------------------------------
    if (!(NPC == 1 || NPC == 2 || NPC == 4 || NPC == 8 || NPC == 16)) begin : g_bad_npc
        $error("boron_inv_sub_unit: NPC must be 1, 2, 4, 8 or 16");
    end

    localparam int NSTEP = 16 / NPC;                          // SUB cycles per job
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;   // counter width
    localparam logic [CW-1:0] CNT_LAST = CW'(NSTEP - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_KEY  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // -----------------------------------------------------------------------
    // Inverse S-box
    // -----------------------------------------------------------------------
    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hA;
            4'h1: y = 4'h3;
            4'h2: y = 4'h9;
            4'h3: y = 4'hE;
            4'h4: y = 4'h1;
            4'h5: y = 4'hD;
            4'h6: y = 4'hF;
            4'h7: y = 4'h4;
            4'h8: y = 4'hC;
            4'h9: y = 4'h5;
            4'hA: y = 4'h7;
            4'hB: y = 4'h2;
            4'hC: y = 4'h6;
            4'hD: y = 4'h8;
            4'hE: y = 4'h0;
            default: y = 4'hB;
        endcase
        return y;
    endfunction

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [63:0]     data_q,  data_d;
    logic [63:0]     key_q,   key_d;
    // Goes high on the first edge after reset release. It keeps in_ready low
    // for the whole reset period (where the FSM already sits in IDLE) without
    // routing rst itself to an output.
    logic            alive_q;

    logic            in_ready_w;
    logic [63:0]     sub_data;

    assign in_ready_w = alive_q && (state_q == S_IDLE);

    // -----------------------------------------------------------------------
    // Substitution slice: nibbles cnt*NPC .. cnt*NPC+NPC-1 replaced, rest held
    // -----------------------------------------------------------------------
    always_comb begin
        sub_data = data_q;
        for (int k = 0; k < 16; k++) begin
            if (CW'(k / NPC) == cnt_q) begin
                sub_data[4*k +: 4] = inv_sbox(data_q[4*k +: 4]);
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and datapath
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        key_d   = key_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_w) begin
                    data_d  = bus.in_state;
                    key_d   = bus.in_key;
                    cnt_d   = '0;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                data_d = sub_data;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_KEY;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_KEY: begin
                data_d  = data_q ^ key_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                // Result held in data_q until downstream takes it.
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            key_q   <= '0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            key_q   <= key_d;
            alive_q <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (registered-state decodes only)
    // -----------------------------------------------------------------------
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_state = data_q;
    assign busy          = (state_q != S_IDLE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_boron_inv_sub_unit.sv
// ---------------------------------------------------------------------------
// tb_boron_inv_sub_unit
//
// Five instances (NPC = 4, 1, 2, 8, 16) share clk/rst; each has its own
// interface and handshake signals. Jobs run one at a time; expected results
// come from a nibble-wise model whose inverse table is built by inverting the
// forward S-box, and are pushed to exp_q at drive time and popped by the
// output monitor on each output transfer.
// ---------------------------------------------------------------------------
module tb_boron_inv_sub_unit;

  localparam int ND = 5;
  localparam int NPCS [ND] = '{4, 1, 2, 8, 16};
  localparam int LATS [ND] = '{5, 17, 9, 3, 2};

  logic clk;
  logic rst;

  logic [ND-1:0] in_valid_v;
  logic [ND-1:0] in_ready_v;
  logic [ND-1:0] out_valid_v;
  logic [ND-1:0] out_ready_v;
  logic [ND-1:0] busy_v;
  logic [63:0]   in_state_a  [ND];
  logic [63:0]   in_key_a    [ND];
  logic [63:0]   out_state_a [ND];
  logic [1:0]    dbg_a       [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    boron_inv_sub_unit_if u_if ();
    assign u_if.in_valid  = in_valid_v[g];
    assign u_if.in_state  = in_state_a[g];
    assign u_if.in_key    = in_key_a[g];
    assign u_if.out_ready = out_ready_v[g];
    assign in_ready_v[g]  = u_if.in_ready;
    assign out_valid_v[g] = u_if.out_valid;
    assign out_state_a[g] = u_if.out_state;

    boron_inv_sub_unit #(.NPC(NPCS[g])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (u_if.slave),
      .busy      (busy_v[g]),
      .dbg_state (dbg_a[g])
    );
  end

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] fwd_tab [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                               4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
  logic [3:0] inv_tab [16];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] s, input logic [63:0] k);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = inv_tab[s[4*i +: 4]];
    return r ^ k;
  endfunction

  // Output monitor: every transfer must match the oldest expectation.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (!rst && out_valid_v[d] && out_ready_v[d]) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(out_valid_v[d]), 64'd0);
        end else begin
          check("sb_out", out_state_a[d], exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_job(input int d, input logic [63:0] st, input logic [63:0] key,
                         input string tag);
    int n;
    @(negedge clk);
    in_state_a[d]  = st;
    in_key_a[d]    = key;
    in_valid_v[d]  = 1'b1;
    out_ready_v[d] = 1'b1;
    exp_q.push_back(model(st, key));
    n = 0;
    while (!in_ready_v[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check({tag, "_accept_timeout"}, 64'(in_ready_v[d]), 64'd1);
      in_valid_v[d] = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    @(negedge clk);  // accept edge has passed
    in_valid_v[d] = 1'b0;
    in_state_a[d] = {$urandom, $urandom};  // must not affect the job
    in_key_a[d]   = {$urandom, $urandom};
    n = 0;
    while (!out_valid_v[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(LATS[d]));
    @(negedge clk);  // output transfer edge has passed
    check({tag, "_ovalid_drop"}, 64'(out_valid_v[d]), 64'd0);
    check({tag, "_iready_back"}, 64'(in_ready_v[d]), 64'd1);
  endtask

  // ---------------- main ----------------
  initial begin
    logic [63:0] st;
    logic [63:0] hold;
    int n;
    int seen;

    for (int v = 0; v < 16; v++) inv_tab[fwd_tab[v]] = 4'(v);

    // Reset, with in_valid/out_ready asserted to show they are ignored.
    rst         = 1'b1;
    in_valid_v  = '1;
    out_ready_v = '1;
    for (int d = 0; d < ND; d++) begin
      in_state_a[d] = 64'h0123456789ABCDEF;
      in_key_a[d]   = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready_v), 64'd0);
    check("rst_out_valid", 64'(out_valid_v), 64'd0);
    check("rst_busy", 64'(busy_v), 64'd0);
    check("rst_out_state", out_state_a[0], 64'd0);
    in_valid_v  = '0;
    out_ready_v = '0;
    rst = 1'b0;
    #1;
    check("rel_in_ready_low", 64'(in_ready_v), 64'd0);
    @(negedge clk);
    check("rel_in_ready", 64'(in_ready_v), 64'h1F);
    check("rel_out_valid", 64'(out_valid_v), 64'd0);
    check("rel_busy", 64'(busy_v), 64'd0);

    // Main vectors on NPC=4.
    run_job(0, 64'h0123456789ABCDEF, 64'd0, "k0");
    check("k0_value", out_state_a[0], 64'hA39E1DF4C572680B);
    for (int d = 0; d < ND; d++) begin
      run_job(d, 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF, $sformatf("kf_npc%0d", NPCS[d]));
      check($sformatf("kf_value_npc%0d", NPCS[d]), out_state_a[d], 64'h5C61E20B3A8D97F4);
    end

    // Round trip through the forward S-box image.
    run_job(0, 64'hE4B179CAD20F8536, 64'd0, "rtrip");
    check("rtrip_value", out_state_a[0], 64'h0123456789ABCDEF);

    // Every nibble value in every position.
    for (int v = 0; v < 16; v++) begin
      for (int p = 0; p < 16; p++) st[4*p +: 4] = 4'((v + p) & 15);
      run_job(0, st, 64'd0, "exh");
    end

    // Random jobs with random keys on every instance.
    for (int d = 0; d < ND; d++) begin
      repeat (3) run_job(d, {$urandom, $urandom}, {$urandom, $urandom}, "rnd");
    end

    // Backpressure on NPC=4.
    @(negedge clk);
    out_ready_v[0] = 1'b0;
    in_state_a[0]  = 64'h0123456789ABCDEF;
    in_key_a[0]    = 64'h0F0F0F0F0F0F0F0F;
    in_valid_v[0]  = 1'b1;
    exp_q.push_back(model(64'h0123456789ABCDEF, 64'h0F0F0F0F0F0F0F0F));
    n = 0;
    while (!in_ready_v[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    n = 0;
    while (!out_valid_v[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_latency", 64'(n), 64'd5);
    hold = out_state_a[0];
    check("bp_value", hold, model(64'h0123456789ABCDEF, 64'h0F0F0F0F0F0F0F0F));
    for (int i = 0; i < 10; i++) begin
      in_valid_v[0] = 1'(i & 1);
      in_state_a[0] = {$urandom, $urandom};
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid_v[0]), 64'd1);
      check("bp_out_state", out_state_a[0], hold);
      check("bp_in_ready", 64'(in_ready_v[0]), 64'd0);
    end
    in_valid_v[0] = 1'b0;
    @(posedge clk);
    #1 out_ready_v[0] = 1'b1;
    @(negedge clk);  // monitor takes the transfer here
    @(negedge clk);
    check("bp_out_valid_drop", 64'(out_valid_v[0]), 64'd0);
    check("bp_in_ready_back", 64'(in_ready_v[0]), 64'd1);
    check("bp_queue_drained", 64'(exp_q.size()), 64'd0);

    // Mid-job reset during SUB with cnt=2.
    @(negedge clk);
    in_state_a[0]  = {$urandom, $urandom};
    in_key_a[0]    = {$urandom, $urandom};
    in_valid_v[0]  = 1'b1;
    out_ready_v[0] = 1'b1;
    n = 0;
    while (!in_ready_v[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mr_busy_before", 64'(busy_v[0]), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mr_busy", 64'(busy_v[0]), 64'd0);
    check("mr_in_ready", 64'(in_ready_v[0]), 64'd0);
    check("mr_out_valid", 64'(out_valid_v[0]), 64'd0);
    check("mr_out_state", out_state_a[0], 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid_v[0]) seen = 1;
    end
    check("mr_no_output", 64'(seen), 64'd0);
    run_job(0, 64'd0, 64'd0, "mr_fresh");
    check("mr_fresh_value", out_state_a[0], 64'hAAAAAAAAAAAAAAAA);

    repeat (3) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
